// File: rtl/soc_reset_pkg.sv
// Shared definitions for the SoC reset sequencer: state encoding and
// debug/status field widths. Also used by the SoC top and the port-A
// debug mux.
package soc_reset_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LOST_W  = 8;

  // Encodings are visible on state_out, so they are fixed
  typedef enum logic [STATE_W-1:0] {
    SeqReset    = 3'd0,
    SeqHold     = 3'd1,
    SeqWaitLock = 3'd2,
    SeqRelease  = 3'd3,
    SeqRun      = 3'd4
  } seq_state_e;

endpackage

// File: rtl/soc_reset_sequencer_if.sv
// Status/control bundle of the reset sequencer.
//   master: drives pll_locked_in, sw_reset_req; observes the outputs
//   slave : the sequencer; drives rst_out, lock_ok, seq_done, state_out,
//           lock_lost_count
interface soc_reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 3
);
  import soc_reset_pkg::*;

  logic                   pll_locked_in;
  logic                   sw_reset_req;
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   lock_ok;
  logic                   seq_done;
  logic [STATE_W-1:0]     state_out;
  logic [LOST_W-1:0]      lock_lost_count;

  modport master (
    output pll_locked_in, sw_reset_req,
    input  rst_out, lock_ok, seq_done, state_out, lock_lost_count
  );

  modport slave (
    input  pll_locked_in, sw_reset_req,
    output rst_out, lock_ok, seq_done, state_out, lock_lost_count
  );

endinterface

// File: rtl/soc_reset_sequencer_lock_filter.sv
// Consecutive-cycle PLL lock qualifier.
//   clk, reset  : clock, synchronous active-high reset
//   locked_in   : raw PLL lock
//   clear       : force the run-length counter to zero
//   enable      : count while high
//   qualified_c : combinational; high on the cycle that completes
//                 LOCK_STABLE_CYCLES consecutive locked cycles
module lock_filter #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic locked_in,
  input  logic clear,
  input  logic enable,
  output logic qualified_c
);

  localparam int unsigned LW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE_CYCLES - 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;

  // Run length of locked cycles; any unlocked cycle restarts it
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (clear) begin
      lock_cnt_d = '0;
    end else if (enable) begin
      if (!locked_in) lock_cnt_d = '0;
      else            lock_cnt_d = lock_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) lock_cnt_q <= '0;
    else       lock_cnt_q <= lock_cnt_d;
  end

  assign qualified_c = enable && locked_in && (lock_cnt_q == LOCK_LAST);

endmodule

// File: rtl/soc_reset_sequencer.sv
// SoC reset sequencer: holds all domains in reset, qualifies PLL lock,
// then releases domains in index order with a fixed stagger.
//   clk, reset : free-running clock, synchronous active-high reset
//   bus        : slave side of soc_reset_sequencer_if (lock/sw-reset in,
//                per-domain resets, lock_ok, seq_done, state, loss count out)
module soc_reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS        = 3,
  parameter int unsigned HOLD_CYCLES        = 32768,
  parameter int unsigned LOCK_STABLE_CYCLES = 1048576,
  parameter int unsigned STAGGER_CYCLES     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  soc_reset_sequencer_if.slave        bus
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned SW = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned IW = $clog2(NUM_DOMAINS + 1);

  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0]     STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(NUM_DOMAINS - 1);
  localparam logic [LOST_W-1:0] LOST_MAX  = '1;

  seq_state_e             state_q, state_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]          stagger_cnt_q, stagger_cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   lock_ok_q, lock_ok_d;
  logic                   seq_done_q, seq_done_d;
  logic [LOST_W-1:0]      lost_q, lost_d;

  logic                   qualified_c;
  logic                   lock_loss_c;
  logic [NUM_DOMAINS-1:0] release_mask_c;

  lock_filter #(
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_filter (
    .clk        (clk),
    .reset      (reset),
    .locked_in  (bus.pll_locked_in),
    .clear      (state_q != SeqWaitLock),
    .enable     (state_q == SeqWaitLock),
    .qualified_c(qualified_c)
  );

  // One-hot of the domain released next
  always_comb begin
    release_mask_c = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (idx_q == IW'(k)) release_mask_c[k] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    stagger_cnt_d = stagger_cnt_q;
    idx_d         = idx_q;
    rst_out_d     = rst_out_q;
    lock_ok_d     = lock_ok_q;
    seq_done_d    = seq_done_q;
    lost_d        = lost_q;

    lock_loss_c = ((state_q == SeqRelease) || (state_q == SeqRun)) && !bus.pll_locked_in;

    if (bus.sw_reset_req || lock_loss_c) begin
      // Restart; a software request masks a coincident lock loss
      state_d       = SeqReset;
      rst_out_d     = '1;
      lock_ok_d     = 1'b0;
      seq_done_d    = 1'b0;
      hold_cnt_d    = '0;
      stagger_cnt_d = '0;
      idx_d         = '0;
      if (!bus.sw_reset_req && (lost_q != LOST_MAX)) lost_d = lost_q + LOST_W'(1);
    end else begin
      case (state_q)
        SeqReset: begin
          state_d    = SeqHold;
          hold_cnt_d = '0;
          rst_out_d  = '1;
          lock_ok_d  = 1'b0;
          seq_done_d = 1'b0;
        end
        SeqHold: begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_q == HOLD_LAST) state_d = SeqWaitLock;
        end
        SeqWaitLock: begin
          if (qualified_c) begin
            state_d       = SeqRelease;
            lock_ok_d     = 1'b1;
            stagger_cnt_d = '0;
            idx_d         = '0;
          end
        end
        SeqRelease: begin
          if (stagger_cnt_q == STAG_LAST) begin
            rst_out_d     = rst_out_q & ~release_mask_c;
            stagger_cnt_d = '0;
            idx_d         = idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              state_d    = SeqRun;
              seq_done_d = 1'b1;
            end
          end else begin
            stagger_cnt_d = stagger_cnt_q + SW'(1);
          end
        end
        SeqRun: begin
        end
        default: begin
          // Corrupted encoding: fall back to a full restart
          state_d       = SeqReset;
          rst_out_d     = '1;
          lock_ok_d     = 1'b0;
          seq_done_d    = 1'b0;
          hold_cnt_d    = '0;
          stagger_cnt_d = '0;
          idx_d         = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SeqReset;
      hold_cnt_q    <= '0;
      stagger_cnt_q <= '0;
      idx_q         <= '0;
      rst_out_q     <= '1;
      lock_ok_q     <= 1'b0;
      seq_done_q    <= 1'b0;
      lost_q        <= '0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      stagger_cnt_q <= stagger_cnt_d;
      idx_q         <= idx_d;
      rst_out_q     <= rst_out_d;
      lock_ok_q     <= lock_ok_d;
      seq_done_q    <= seq_done_d;
      lost_q        <= lost_d;
    end
  end

  assign bus.rst_out         = rst_out_q;
  assign bus.lock_ok         = lock_ok_q;
  assign bus.seq_done        = seq_done_q;
  assign bus.state_out       = state_q;
  assign bus.lock_lost_count = lost_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer (3 domains, hold 4, lock 8,
// stagger 2). Stimulus pushes hand-computed expectations tagged with the
// clock edge they apply to; a negedge monitor pops and compares them.
module tb_soc_reset_sequencer;
  import soc_reset_pkg::*;

  localparam int unsigned ND = 3;

  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  rst;
    logic        lock_ok;
    logic        done;
    logic [2:0]  st;
    logic [7:0]  lost;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   base  = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t mon_e;

  soc_reset_sequencer_if #(.NUM_DOMAINS(ND)) bus ();

  soc_reset_sequencer #(
    .NUM_DOMAINS       (ND),
    .HOLD_CYCLES       (4),
    .LOCK_STABLE_CYCLES(8),
    .STAGGER_CYCLES    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectation for the state visible after edge base+rel
  task automatic chk(input int rel, input string name, input logic [2:0] r,
                     input logic lo, input logic d, input logic [2:0] s,
                     input logic [7:0] l);
    exp_t e;
    e.cyc = base + rel; e.name = name; e.rst = r; e.lock_ok = lo;
    e.done = d; e.st = s; e.lost = l;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int rel);
    while (cyc < base + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (bus.rst_out === mon_e.rst && bus.lock_ok === mon_e.lock_ok &&
          bus.seq_done === mon_e.done && bus.state_out === mon_e.st &&
          bus.lock_lost_count === mon_e.lost && mon_e.cyc == cyc) begin
        n_pass++;
      end else begin
        $display("FAIL %s @cyc %0d: got rst=%b lock_ok=%b done=%b st=%0d lost=%0d, want rst=%b lock_ok=%b done=%b st=%0d lost=%0d (due cyc %0d)",
                 mon_e.name, cyc, bus.rst_out, bus.lock_ok, bus.seq_done, bus.state_out,
                 bus.lock_lost_count, mon_e.rst, mon_e.lock_ok, mon_e.done, mon_e.st,
                 mon_e.lost, mon_e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.pll_locked_in = 1'b1;
    bus.sw_reset_req  = 1'b0;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    base = cyc;
    chk(0, "reset_state", 3'b111, 0, 0, 3'd0, 8'd0);
    reset = 1'b0;

    // Scenario 1: clean sequence, edge n = base + n
    chk(1,  "s1_hold",      3'b111, 0, 0, 3'd1, 0);
    chk(4,  "s1_hold_end",  3'b111, 0, 0, 3'd1, 0);
    chk(5,  "s1_waitlock",  3'b111, 0, 0, 3'd2, 0);
    chk(12, "s1_wait_last", 3'b111, 0, 0, 3'd2, 0);
    chk(13, "s1_release",   3'b111, 1, 0, 3'd3, 0);
    chk(14, "s1_stag",      3'b111, 1, 0, 3'd3, 0);
    chk(15, "s1_rel0",      3'b110, 1, 0, 3'd3, 0);
    chk(16, "s1_rel0_hold", 3'b110, 1, 0, 3'd3, 0);
    chk(17, "s1_rel1",      3'b100, 1, 0, 3'd3, 0);
    chk(18, "s1_rel1_hold", 3'b100, 1, 0, 3'd3, 0);
    chk(19, "s1_run",       3'b000, 1, 1, 3'd4, 0);
    chk(20, "s1_run_hold",  3'b000, 1, 1, 3'd4, 0);
    wait_until(20);

    // Scenario 3: lock loss in Run, then full restart
    bus.pll_locked_in = 1'b0;
    chk(21, "s3_loss_run", 3'b111, 0, 0, 3'd0, 8'd1);
    wait_until(21);
    bus.pll_locked_in = 1'b1;
    base = cyc;
    chk(1,  "s3_re_hold",    3'b111, 0, 0, 3'd1, 8'd1);
    chk(13, "s3_re_release", 3'b111, 1, 0, 3'd3, 8'd1);
    chk(15, "s3_re_rel0",    3'b110, 1, 0, 3'd3, 8'd1);
    chk(16, "s6_pre_reset",  3'b110, 1, 0, 3'd3, 8'd1);
    wait_until(16);

    // Scenario 6: reset in the middle of Release
    reset = 1'b1;
    chk(17, "s6_reset", 3'b111, 0, 0, 3'd0, 8'd0);
    wait_until(18);
    reset = 1'b0;
    base = cyc;

    // Scenario 2: one-cycle lock glitch after 5 locked cycles in WaitLock
    chk(5,  "s2_waitlock",  3'b111, 0, 0, 3'd2, 0);
    chk(10, "s2_locked5",   3'b111, 0, 0, 3'd2, 0);
    chk(11, "s2_glitch",    3'b111, 0, 0, 3'd2, 0);
    chk(13, "s2_no_early",  3'b111, 0, 0, 3'd2, 0);
    chk(18, "s2_wait_last", 3'b111, 0, 0, 3'd2, 0);
    chk(19, "s2_release",   3'b111, 1, 0, 3'd3, 0);
    chk(20, "s2_stag",      3'b111, 1, 0, 3'd3, 0);
    chk(21, "s2_rel0",      3'b110, 1, 0, 3'd3, 0);
    chk(22, "s2_rel0_hold", 3'b110, 1, 0, 3'd3, 0);
    wait_until(10);
    bus.pll_locked_in = 1'b0;
    wait_until(11);
    bus.pll_locked_in = 1'b1;
    wait_until(22);

    // Scenario 4: sw reset coincident with lock loss in Release
    bus.pll_locked_in = 1'b0;
    bus.sw_reset_req  = 1'b1;
    chk(23, "s4_sw_and_loss", 3'b111, 0, 0, 3'd0, 8'd0);
    wait_until(23);
    bus.pll_locked_in = 1'b1;
    bus.sw_reset_req  = 1'b0;
    base = cyc;

    // Scenario 5: 256 lock losses in Release, count saturates
    for (int i = 1; i <= 256; i++) begin
      chk(13, "s5_release", 3'b111, 1, 0, 3'd3, 8'((i - 1) > 255 ? 255 : (i - 1)));
      chk(14, "s5_loss",    3'b111, 0, 0, 3'd0, 8'(i > 255 ? 255 : i));
      wait_until(13);
      bus.pll_locked_in = 1'b0;
      wait_until(14);
      bus.pll_locked_in = 1'b1;
      base = cyc;
    end
    chk(1, "s5_sat_restart", 3'b111, 0, 0, 3'd1, 8'd255);
    wait_until(3);

    n_checks++;
    if (bus.lock_lost_count === 8'd255) begin
      n_pass++;
    end else begin
      $display("FAIL s5_sat_direct: lock_lost_count=%0d, want 255", bus.lock_lost_count);
    end

    n_checks++;
    if (bus.state_out === SeqHold) begin
      n_pass++;
    end else begin
      $display("FAIL s5_state_direct: state_out=%0d, want %0d", bus.state_out, SeqHold);
    end

    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      n_checks++;
      $display("FAIL %s: expectation for cyc %0d never checked, now cyc %0d",
               mon_e.name, mon_e.cyc, cyc);
    end
    if (n_pass == n_checks) begin
      $display("PASS all checks");
    end else begin
      $display("FAIL %0d of %0d checks failed", n_checks - n_pass, n_checks);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
